// File: rtl/pkg_cpu.sv
// Shared CPU bus definitions: data/address widths, access-size and responder state enums,
// plus small helpers for lane alignment used by the memory responder.
package pkg_cpu;

  localparam int CPU_DATA_BUS_MAX_MSB_POS = 31;
  localparam int CPU_ADDR_BUS_MSB_POS     = 31;
  localparam int CPU_DATA_W               = CPU_DATA_BUS_MAX_MSB_POS + 1;
  localparam int CPU_ADDR_W               = CPU_ADDR_BUS_MSB_POS + 1;
  localparam int CPU_BYTE_LANES           = CPU_DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } access_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } resp_state_e;

  // The reserved encoding behaves exactly like a word access.
  function automatic access_size_e norm_size(input access_size_e sz);
    return (sz == SIZE_RSVD) ? SIZE_WORD : sz;
  endfunction

  function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lo[0];
      default:   bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [1:0] aligned_offset(input access_size_e sz, input logic [1:0] lo);
    logic [1:0] off;
    case (sz)
      SIZE_BYTE: off = lo;
      SIZE_HALF: off = {lo[1], 1'b0};
      default:   off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [CPU_BYTE_LANES-1:0] lane_enables(input access_size_e sz,
                                                             input logic [1:0] off);
    logic [CPU_BYTE_LANES-1:0] be;
    case (sz)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/cpu_mem_bank.sv
// Byte-lane RAM for the CPU memory responder: 2^WORDS_LOG2 x 32 bits,
// combinational read, synchronous write gated per byte lane.
module cpu_mem_bank
  import pkg_cpu::*;
#(
  parameter int WORDS_LOG2 = 10
) (
  input  logic                      clk,
  input  logic [WORDS_LOG2-1:0]     word_idx,
  input  logic                      wr_en,
  input  logic [CPU_BYTE_LANES-1:0] byte_en,
  input  logic [CPU_DATA_W-1:0]     wdata,
  output logic [CPU_DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  // One narrow array per lane keeps byte writes free of read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < CPU_BYTE_LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          lane_mem[word_idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU data-bus memory responder: latches a request, waits WAIT_STATES cycles, then performs
// the access with a one-cycle ready strobe. Optional misalignment error: CPU_MEM_RESP_MISALIGN_CHECK_EN.
module cpu_mem_responder
  import pkg_cpu::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int WAIT_STATES    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_rdwr,
  input  logic                  req_write,
  input  logic [1:0]            req_data_size,
  input  logic [CPU_ADDR_W-1:0] addr_in,
  input  logic [CPU_DATA_W-1:0] wr_data,
  output logic [CPU_DATA_W-1:0] data_out,
  output logic                  ready,
  output logic                  err
);

  localparam int         LOW_W     = MEM_WORDS_LOG2 + 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  resp_state_e            state_reg;
  logic [3:0]             cnt_reg;
  logic [LOW_W-1:0]       addr_reg;
  access_size_e           size_reg;
  logic                   write_reg;
  logic [CPU_DATA_W-1:0]  wdata_reg;

  access_size_e              size_eff;
  logic [1:0]                lane_off;
  logic [CPU_BYTE_LANES-1:0] byte_en;
  logic                      misaligned;
  logic                      bank_we;
  logic [CPU_DATA_W-1:0]     bank_wdata;
  logic [CPU_DATA_W-1:0]     bank_rdata;
  logic [CPU_DATA_W-1:0]     rd_shifted;
  logic [CPU_DATA_W-1:0]     rd_value;
  logic                      unused_addr;

  // Address bits above the RAM window only alias and are deliberately dropped.
  assign unused_addr = ^addr_in[CPU_ADDR_W-1:LOW_W];

  assign size_eff = norm_size(size_reg);
  assign lane_off = aligned_offset(size_eff, addr_reg[1:0]);
  assign byte_en  = lane_enables(size_eff, lane_off);

`ifdef CPU_MEM_RESP_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(size_eff, addr_reg[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign bank_we = (state_reg == RESPOND) && write_reg && !misaligned;

  // Replicating the right-justified write data lets the lane enables pick the target bytes.
  always_comb begin
    bank_wdata = wdata_reg;
    case (size_eff)
      SIZE_BYTE: bank_wdata = {4{wdata_reg[7:0]}};
      SIZE_HALF: bank_wdata = {2{wdata_reg[15:0]}};
      default:   bank_wdata = wdata_reg;
    endcase
  end

  always_comb begin
    rd_shifted = bank_rdata >> {lane_off, 3'b000};
    rd_value   = bank_rdata;
    case (size_eff)
      SIZE_BYTE: rd_value = {24'h0, rd_shifted[7:0]};
      SIZE_HALF: rd_value = {16'h0, rd_shifted[15:0]};
      default:   rd_value = bank_rdata;
    endcase
    if (misaligned) begin
      rd_value = '0;
    end
  end

  cpu_mem_bank #(
    .WORDS_LOG2 (MEM_WORDS_LOG2)
  ) u_bank (
    .clk      (clk),
    .word_idx (addr_reg[LOW_W-1:2]),
    .wr_en    (bank_we),
    .byte_en  (byte_en),
    .wdata    (bank_wdata),
    .rdata    (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      size_reg  <= SIZE_BYTE;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_rdwr) begin
            addr_reg  <= addr_in[LOW_W-1:0];
            size_reg  <= access_size_e'(req_data_size);
            write_reg <= req_write;
            wdata_reg <= wr_data;
            cnt_reg   <= WAIT_LOAD;
            state_reg <= (WAIT_LOAD != 4'd0) ? WAIT : RESPOND;
          end
        end
        WAIT: begin
          if (cnt_reg <= 4'd1) begin
            state_reg <= RESPOND;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESPOND: begin
          ready     <= 1'b1;
          err       <= misaligned;
          if (!write_reg) begin
            data_out <= rd_value;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: two instances (3 and 0 wait states) share one
// request bus; results are compared against a byte-array memory model.
module tb_cpu_mem_responder;

  localparam int          W3       = 3;
  localparam int          LOG2     = 10;
  localparam int unsigned MEM_MASK = (1 << (LOG2 + 2)) - 1;

`ifdef CPU_MEM_RESP_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rdwr = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_data_size = 2'd0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] data3, data0;
  logic        ready3, ready0, err3, err0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.MEM_WORDS_LOG2(LOG2), .WAIT_STATES(W3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_rdwr(req_rdwr), .req_write(req_write),
    .req_data_size(req_data_size), .addr_in(addr_in), .wr_data(wr_data),
    .data_out(data3), .ready(ready3), .err(err3)
  );

  cpu_mem_responder #(.MEM_WORDS_LOG2(LOG2), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_rdwr(req_rdwr), .req_write(req_write),
    .req_data_size(req_data_size), .addr_in(addr_in), .wr_data(wr_data),
    .data_out(data0), .ready(ready0), .err(err0)
  );

  int checks = 0;
  int errors = 0;
  bit [7:0]    mem_model [int unsigned];
  logic [31:0] last3 = 32'h0;
  logic [31:0] last0 = 32'h0;
  bit          force0 = 1'b0;
  logic [31:0] force0_val = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return MIS_EN && ((a % n) != 0);
  endfunction

  // Access start address inside the RAM window, forced down to its natural alignment.
  function automatic int unsigned model_base(input logic [1:0] sz, input logic [31:0] a);
    int unsigned n = nbytes(sz);
    return ((a & MEM_MASK) / n) * n;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int unsigned b = model_base(sz, a);
    if (model_mis(sz, a)) return 32'h0;
    for (int i = 0; i < nbytes(sz); i++) begin
      if (mem_model.exists(b + i)) v = v | (32'(mem_model[b + i]) << (8 * i));
    end
    return v;
  endfunction

  task automatic model_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned b = model_base(sz, a);
    if (model_mis(sz, a)) return;
    for (int i = 0; i < nbytes(sz); i++) mem_model[b + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic garble_bus();
    req_rdwr      = 1'b0;
    req_write     = 1'($urandom);
    req_data_size = 2'($urandom);
    addr_in       = $urandom;
    wr_data       = $urandom;
  endtask

  // One request; hold = number of accepting edges req_rdwr stays high for.
  task automatic txn(input string tag, input bit w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input logic [8:0] mask3,
                     input logic [8:0] mask0);
    logic [31:0] exp3, exp0, rd;
    logic [8:0]  m3 = '0, m0 = '0, e3 = '0, e0 = '0;
    bit mis;
    mis = model_mis(sz, a);
    rd  = w ? 32'h0 : model_read(sz, a);
    if (w) model_write(sz, a, d);
    exp3 = w ? last3 : rd;
    exp0 = w ? last0 : (force0 ? force0_val : rd);
    @(negedge clk);
    req_rdwr = 1'b1; req_write = w; req_data_size = sz; addr_in = a; wr_data = d;
    @(posedge clk); #1;
    if (hold <= 1) garble_bus();
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == hold - 1) garble_bus();
      m3[k-1] = ready3; m0[k-1] = ready0; e3[k-1] = err3; e0[k-1] = err0;
      if (ready3) check({tag, ".data3"}, data3, exp3);
      if (ready0) check({tag, ".data0"}, data0, exp0);
    end
    check({tag, ".ready3"}, {23'h0, m3}, {23'h0, mask3});
    check({tag, ".ready0"}, {23'h0, m0}, {23'h0, mask0});
    check({tag, ".err3"}, {23'h0, e3}, mis ? {23'h0, mask3} : 32'h0);
    check({tag, ".err0"}, {23'h0, e0}, mis ? {23'h0, mask0} : 32'h0);
    if (!w) begin
      last3 = exp3;
      last0 = exp0;
    end
    $display("txn %s w=%0d sz=%0d addr=%h wdata=%h exp3=%h exp0=%h", tag, w, sz, a, d, exp3, exp0);
  endtask

  task automatic op(input string tag, input bit w, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    txn(tag, w, sz, a, d, 1, 9'(1 << W3), 9'b000000001);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready3", {31'h0, ready3}, 32'h0);
    check("rst.err3", {31'h0, err3}, 32'h0);
    check("rst.data3", data3, 32'h0);
    check("rst.ready0", {31'h0, ready0}, 32'h0);
    check("rst.data0", data0, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during WAIT must drop the pending write on the 3-wait-state instance.
    op("pre10", 1'b1, 2'd2, 32'h10, 32'h01020304);
    op("rd10", 1'b0, 2'd2, 32'h10, 32'h0);
    @(negedge clk);
    req_rdwr = 1'b1; req_write = 1'b1; req_data_size = 2'd2; addr_in = 32'h10; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    garble_bus();
    @(posedge clk); #1;
    check("rstw.ready3_pre", {31'h0, ready3}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rstw.data3", data3, 32'h0);
    check("rstw.data0", data0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        @(negedge clk) rst_n = 1'b1;
      end
      @(posedge clk); #1;
      check("rstw.ready3", {31'h0, ready3}, 32'h0);
      check("rstw.err3", {31'h0, err3}, 32'h0);
    end
    last3 = 32'h0; last0 = 32'h0;
    force0 = 1'b1; force0_val = 32'hDEADBEEF;
    op("rstw.rd10", 1'b0, 2'd2, 32'h10, 32'h0);
    force0 = 1'b0;
    op("resync10", 1'b1, 2'd2, 32'h10, 32'h55AA55AA);

    op("wr40", 1'b1, 2'd2, 32'h40, 32'h12345678);
    op("rdb41", 1'b0, 2'd0, 32'h41, 32'h0);
    op("rdh42", 1'b0, 2'd1, 32'h42, 32'h0);
    op("wr80", 1'b1, 2'd2, 32'h80, 32'hAABBCCDD);
    op("wrb83", 1'b1, 2'd0, 32'h83, 32'h11);
    op("rd80", 1'b0, 2'd2, 32'h80, 32'h0);
    op("wrhi", 1'b1, 2'd2, 32'h0000_1004, 32'hCAFE0001);
    op("rdalias", 1'b0, 2'd2, 32'h0000_0004, 32'h0);
    op("wr20", 1'b1, 2'd2, 32'h20, 32'h0BADF00D);
    op("wrmis22", 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF);
    op("rd20", 1'b0, 2'd2, 32'h20, 32'h0);
    op("rdmis_h", 1'b0, 2'd1, 32'h41, 32'h0);
    op("rsvd", 1'b0, 2'd3, 32'h80, 32'h0);

    // Held request: zero-wait instance completes three reads, one every two cycles.
    txn("b2b", 1'b0, 2'd2, 32'h40, 32'h0, 5, 9'(1 << W3), 9'b000010101);

    for (int i = 0; i < 32; i++) op("init", 1'b1, 2'd2, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 127)) + ($urandom & 32'hFFFF_F000);
      op("rand", 1'($urandom), 2'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
